// File: rtl/iob_timer_mc_pkg.sv
// Shared constants for the multi-channel timer: bus widths, register map and
// control-bit positions.
package iob_timer_mc_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] A_CTRL       = 5'd0;
  localparam logic [ADDR_W-1:0] A_PRESCALE   = 5'd1;
  localparam logic [ADDR_W-1:0] A_SNAP_LO    = 5'd2;
  localparam logic [ADDR_W-1:0] A_SNAP_HI    = 5'd3;
  localparam logic [ADDR_W-1:0] A_IRQ_STATUS = 5'd4;
  localparam logic [ADDR_W-1:0] A_IRQ_ENABLE = 5'd5;
  localparam int                A_CH_BASE    = 8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_SRST = 1;
  localparam int CTRL_SNAP = 2;
  localparam int CH_EN     = 0;
  localparam int CH_PER    = 1;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  // Channels occupy address pairs: reload at 8+2i, control at 9+2i.
  function automatic logic [ADDR_W-1:0] ch_reload_addr(input int i);
    return ADDR_W'(A_CH_BASE + 2*i);
  endfunction

  function automatic logic [ADDR_W-1:0] ch_ctrl_addr(input int i);
    return ADDR_W'(A_CH_BASE + 2*i + 1);
  endfunction
endpackage

// File: rtl/iob_timer_mc_if.sv
// CPU valid/ready bus shared by the timer and its requesters.
interface iob_timer_mc_if;
  import iob_timer_mc_pkg::*;
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output valid, write, address, wdata, input rdata, ready);
  modport slave  (input valid, write, address, wdata, output rdata, ready);
endinterface

// File: rtl/iob_timer_mc_ch.sv
// One reload channel: down-counter with IDLE/RUN state and a one-cycle event
// pulse when the count expires on a tick.
module iob_timer_mc_ch
  import iob_timer_mc_pkg::*;
#(
  parameter int CH_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            soft_rst,
  input  logic            tick,
  input  logic            ctrl_we,
  input  logic            wr_en,
  input  logic            wr_per,
  input  logic [CH_W-1:0] reload,
  output logic            en,
  output logic            periodic,
  output logic            evt
);
  ch_state_t       state;
  logic [CH_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      periodic <= 1'b0;
    end else if (soft_rst) begin
      state <= CH_IDLE;
      cnt   <= '0;
    end else if (ctrl_we) begin
      // a control write overrides any tick in the same cycle
      periodic <= wr_per;
      state    <= wr_en ? CH_RUN : CH_IDLE;
      if (wr_en) cnt <= reload;
    end else if (state == CH_RUN && tick) begin
      if (cnt == '0) begin
        if (periodic) cnt <= reload;
        else          state <= CH_IDLE;
      end else begin
        cnt <= cnt - CH_W'(1);
      end
    end
  end

  assign en  = (state == CH_RUN);
  assign evt = en && tick && (cnt == '0) && !ctrl_we && !soft_rst;
endmodule

// File: rtl/iob_timer_mc.sv
// Multi-channel timer: register file, prescaled free-running counter with
// snapshot, NCH reload channels and a masked, registered interrupt.
module iob_timer_mc
  import iob_timer_mc_pkg::*;
#(
  parameter int COUNT_W = 64,
  parameter int NCH     = 4,
  parameter int CH_W    = 32,
  parameter int PRE_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  iob_timer_mc_if.slave        bus,
  output logic                 irq
);
  logic               we, rd;
  logic               ctrl_we, soft_rst, snap_req, tick, ovf;
  logic               enable;
  logic [PRE_W-1:0]   prescale, pre_cnt;
  logic [COUNT_W-1:0] counter, snap;
  logic [63:0]        snap_ext;
  logic [NCH:0]       irq_status, irq_enable, w1c;
  logic [CH_W-1:0]    ch_reload [NCH];
  logic [NCH-1:0]     ch_en, ch_per, ch_evt, ch_ctrl_we;
  logic [DATA_W-1:0]  rd_mux;

  assign we       = bus.valid && bus.write;
  assign rd       = bus.valid && !bus.write;
  assign ctrl_we  = we && (bus.address == A_CTRL);
  assign soft_rst = ctrl_we && bus.wdata[CTRL_SRST];
  assign snap_req = ctrl_we && bus.wdata[CTRL_SNAP];
  // >= so that lowering PRESCALE below the running count cannot stall ticks
  assign tick     = enable && (pre_cnt >= prescale);
  assign ovf      = tick && (&counter);
  assign snap_ext = 64'(snap);
  assign w1c      = (we && bus.address == A_IRQ_STATUS) ? bus.wdata[NCH:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      counter  <= '0;
      snap     <= '0;
    end else begin
      if (ctrl_we) enable <= bus.wdata[CTRL_EN];
      if (we && bus.address == A_PRESCALE) prescale <= bus.wdata[PRE_W-1:0];
      if (soft_rst) begin
        pre_cnt <= '0;
        counter <= '0;
        snap    <= '0;
      end else begin
        if (snap_req) snap <= counter;
        if (tick) begin
          pre_cnt <= '0;
          counter <= counter + COUNT_W'(1);
        end else if (enable) begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_status <= '0;
      irq_enable <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < NCH; i++) ch_reload[i] <= '0;
    end else begin
      // new events are ORed in after the clear so they win over W1C
      if (soft_rst) irq_status <= '0;
      else          irq_status <= (irq_status & ~w1c) | {ovf, ch_evt};
      if (we && bus.address == A_IRQ_ENABLE) irq_enable <= bus.wdata[NCH:0];
      for (int i = 0; i < NCH; i++)
        if (we && bus.address == ch_reload_addr(i)) ch_reload[i] <= bus.wdata[CH_W-1:0];
      irq <= |(irq_status & irq_enable);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_CTRL:       rd_mux = DATA_W'(enable);
      A_PRESCALE:   rd_mux = DATA_W'(prescale);
      A_SNAP_LO:    rd_mux = snap_ext[31:0];
      A_SNAP_HI:    rd_mux = snap_ext[63:32];
      A_IRQ_STATUS: rd_mux = DATA_W'(irq_status);
      A_IRQ_ENABLE: rd_mux = DATA_W'(irq_enable);
      default:      ;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (bus.address == ch_reload_addr(i)) rd_mux = DATA_W'(ch_reload[i]);
      if (bus.address == ch_ctrl_addr(i))   rd_mux = DATA_W'({ch_per[i], ch_en[i]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= bus.valid;
      bus.rdata <= rd ? rd_mux : '0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_ctrl_we[i] = we && (bus.address == ch_ctrl_addr(i));
    iob_timer_mc_ch #(.CH_W(CH_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .soft_rst (soft_rst),
      .tick     (tick),
      .ctrl_we  (ch_ctrl_we[i]),
      .wr_en    (bus.wdata[CH_EN]),
      .wr_per   (bus.wdata[CH_PER]),
      .reload   (ch_reload[i]),
      .en       (ch_en[i]),
      .periodic (ch_per[i]),
      .evt      (ch_evt[i])
    );
  end
endmodule
